// File: rtl/ram_boot_loader_if.sv
// Byte-stream receive handshake, CPU RAM write port and CPU run control for ram_boot_loader.
// The loader side uses the master modport; the UART/CPU side uses the slave modport.
interface ram_boot_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] Ram_addr;
  logic [15:0] Ram_data;
  logic        WR_RAM_E;
  logic        E;
  logic        cpu_done;

  modport master (
    input  rx_data,
    input  rx_valid,
    input  cpu_done,
    output rx_ready,
    output Ram_addr,
    output Ram_data,
    output WR_RAM_E,
    output E
  );

  modport slave (
    output rx_data,
    output rx_valid,
    output cpu_done,
    input  rx_ready,
    input  Ram_addr,
    input  Ram_data,
    input  WR_RAM_E,
    input  E
  );
endinterface

// File: rtl/ram_boot_loader.sv
// Program loader: assembles big-endian {addr, data} byte frames into CPU RAM writes and starts
// the CPU on the END_ADDR frame. Define BOOT_CHECKSUM_EN to require an XOR checksum byte per frame.
module ram_boot_loader #(
  parameter int unsigned TIMEOUT_CYC = 65535,
  parameter logic [15:0] END_ADDR    = 16'hFFFF,
  parameter int unsigned START_DELAY = 2
) (
  input  logic                CLK,
  input  logic                rst,
  ram_boot_loader_if.master   bus,
  output logic [15:0]         word_count,
  output logic                frame_err,
  output logic                busy
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYC);
  // Last START count before E rises; only used when START_DELAY >= 2.
  localparam logic [15:0] StartLast = 16'(START_DELAY - 2);

  typedef enum logic [2:0] {
    StLoadB0,
    StLoadB1,
    StLoadB2,
    StLoadB3,
    StWrite,
    StStart,
    StRun
`ifdef BOOT_CHECKSUM_EN
    , StLoadCk
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     asm_q, asm_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [15:0]     start_cnt_q, start_cnt_d;
  logic            run_first_q, run_first_d;
  logic [15:0]     addr_q, addr_d;
  logic [15:0]     data_q, data_d;
  logic            wr_q, wr_d;
  logic            e_q, e_d;
  logic [15:0]     wc_q, wc_d;
  logic            ferr_q, ferr_d;
  logic            rx_ready_q, rx_ready_d;
  logic            busy_q, busy_d;
  logic            accept;
  logic            load_next;

  always_comb begin
    state_d     = state_q;
    asm_d       = asm_q;
    tmo_d       = '0;
    start_cnt_d = start_cnt_q;
    run_first_d = run_first_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wr_d        = 1'b0;
    e_d         = e_q;
    wc_d        = wc_q;
    ferr_d      = ferr_q;
    accept      = bus.rx_valid & rx_ready_q;

    unique case (state_q)
      StLoadB0: begin
        if (accept) begin
          asm_d   = {asm_q[23:0], bus.rx_data};
          state_d = StLoadB1;
        end
      end
      StWrite: begin
        if (asm_q[31:16] != END_ADDR) begin
          addr_d  = asm_q[31:16];
          data_d  = asm_q[15:0];
          wr_d    = 1'b1;
          if (wc_q != 16'hFFFF) wc_d = wc_q + 16'd1;
          state_d = StLoadB0;
        end else if (START_DELAY <= 1) begin
          e_d         = 1'b1;
          run_first_d = 1'b1;
          state_d     = StRun;
        end else begin
          start_cnt_d = '0;
          state_d     = StStart;
        end
      end
      StStart: begin
        if (start_cnt_q == StartLast) begin
          e_d         = 1'b1;
          run_first_d = 1'b1;
          state_d     = StRun;
        end else begin
          start_cnt_d = start_cnt_q + 16'd1;
        end
      end
      StRun: begin
        // cpu_done is only trusted once E has already been high for a full cycle.
        if (run_first_q) begin
          run_first_d = 1'b0;
        end else if (bus.cpu_done) begin
          e_d     = 1'b0;
          wc_d    = '0;
          ferr_d  = 1'b0;
          state_d = StLoadB0;
        end
      end
      default: begin
        // Partial frame: timeout wins over a byte offered in the same cycle.
        if (tmo_q == TmoMax) begin
          ferr_d  = 1'b1;
          state_d = StLoadB0;
        end else if (!accept) begin
          tmo_d = tmo_q + 1'b1;
        end else begin
          asm_d = {asm_q[23:0], bus.rx_data};
          if (state_q == StLoadB1) begin
            state_d = StLoadB2;
          end else if (state_q == StLoadB2) begin
            state_d = StLoadB3;
          end else if (state_q == StLoadB3) begin
`ifdef BOOT_CHECKSUM_EN
            state_d = StLoadCk;
`else
            state_d = StWrite;
`endif
          end else begin
`ifdef BOOT_CHECKSUM_EN
            asm_d = asm_q;
            if (bus.rx_data == (asm_q[31:24] ^ asm_q[23:16] ^ asm_q[15:8] ^ asm_q[7:0])) begin
              state_d = StWrite;
            end else begin
              ferr_d  = 1'b1;
              state_d = StLoadB0;
            end
`else
            state_d = StLoadB0;
`endif
          end
        end
      end
    endcase

    load_next = (state_d == StLoadB0) || (state_d == StLoadB1) ||
                (state_d == StLoadB2) || (state_d == StLoadB3);
`ifdef BOOT_CHECKSUM_EN
    load_next = load_next || (state_d == StLoadCk);
`endif
    rx_ready_d = load_next && (tmo_d != TmoMax);
    busy_d     = (state_d != StLoadB0);
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q     <= StLoadB0;
      asm_q       <= '0;
      tmo_q       <= '0;
      start_cnt_q <= '0;
      run_first_q <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      wr_q        <= 1'b0;
      e_q         <= 1'b0;
      wc_q        <= '0;
      ferr_q      <= 1'b0;
      rx_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      asm_q       <= asm_d;
      tmo_q       <= tmo_d;
      start_cnt_q <= start_cnt_d;
      run_first_q <= run_first_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wr_q        <= wr_d;
      e_q         <= e_d;
      wc_q        <= wc_d;
      ferr_q      <= ferr_d;
      rx_ready_q  <= rx_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.rx_ready = rx_ready_q;
  assign bus.Ram_addr = addr_q;
  assign bus.Ram_data = data_q;
  assign bus.WR_RAM_E = wr_q;
  assign bus.E        = e_q;
  assign word_count   = wc_q;
  assign frame_err    = ferr_q;
  assign busy         = busy_q;

endmodule
